// File: rtl/game_pkg.sv
// Shared types and constants for the battleship turn/phase sequencer.
// Nine phases need 4 bits, so the exported state port is 4 bits wide.
package game_pkg;

   typedef enum logic [3:0] {
      IDLE        = 4'd0,
      PLACE       = 4'd1,
      READY       = 4'd2,
      PLAYER_TURN = 4'd3,
      SEND        = 4'd4,
      WAIT_RES    = 4'd5,
      ENEMY_TURN  = 4'd6,
      WIN         = 4'd7,
      LOSE        = 4'd8
   } state_e;

   localparam int unsigned STATE_W = 4;
   localparam logic [7:0]  NO_COR  = 8'hFF;

   function automatic logic cor_valid(input logic [7:0] cor);
      return cor != NO_COR;
   endfunction

endpackage

// File: rtl/game_ctrl_edge_det.sv
// Rising-edge detector with synchronous reset for the mouse button and start button.
// An input that is already high when reset releases must drop before it can fire.
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic din_q, din_d;
   logic armed_q, armed_d;

   // armed_q ensures an input held through reset cannot fire until it has been low
   always_comb begin
      din_d   = din;
      armed_d = armed_q | ~din;
      rise    = din & ~din_q & armed_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         din_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         din_q   <= din_d;
         armed_q <= armed_d;
      end
   end

endmodule

// File: rtl/game_ctrl.sv
// Turn and phase sequencer for battleship: ship placement, shot issue to the
// enemy link with resend on timeout, turn alternation, hit counting and win/lose.
module game_ctrl
   import game_pkg::*;
#(
   parameter int unsigned SHIP_CELLS   = 20,
   parameter int unsigned FIRST_PLAYER = 1,
   parameter int unsigned RES_TIMEOUT  = 50_000_000
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start_btn,
   input  logic                              left,
   input  logic [7:0]                        player_cor,
   input  logic [7:0]                        enemy_cor,
   output logic                              place_we,
   output logic [7:0]                        place_cor,
   output logic                              shot_valid,
   output logic [7:0]                        shot_cor,
   input  logic                              shot_ready,
   input  logic                              res_valid,
   input  logic                              res_hit,
   input  logic                              inc_valid,
   input  logic                              inc_hit,
   output logic [STATE_W-1:0]                state,
   output logic                              my_turn,
   output logic [$clog2(SHIP_CELLS+1)-1:0]   hits_enemy,
   output logic [$clog2(SHIP_CELLS+1)-1:0]   hits_mine,
   output logic                              win,
   output logic                              lose
);

   localparam int unsigned CW = $clog2(SHIP_CELLS + 1);
   localparam int unsigned TW = $clog2(RES_TIMEOUT + 1);
   localparam logic [CW-1:0] CELLS_MAX = CW'(SHIP_CELLS);
   localparam logic [TW-1:0] TMO_LAST  = TW'(RES_TIMEOUT - 1);

   state_e          state_q, state_d;
   logic            place_we_q, place_we_d;
   logic [7:0]      place_cor_q, place_cor_d;
   logic [7:0]      shot_cor_q, shot_cor_d;
   logic [255:0]    placed_map_q, placed_map_d;
   logic [255:0]    shot_map_q, shot_map_d;
   logic [CW-1:0]   placed_cnt_q, placed_cnt_d;
   logic [CW-1:0]   hits_enemy_q, hits_enemy_d;
   logic [CW-1:0]   hits_mine_q, hits_mine_d;
   logic [TW-1:0]   timer_q, timer_d;

   logic click, start;
   logic place_ok, shot_ok;

   edge_det u_click_det (
      .clk  (clk),
      .rst  (rst),
      .din  (left),
      .rise (click)
   );

   edge_det u_start_det (
      .clk  (clk),
      .rst  (rst),
      .din  (start_btn),
      .rise (start)
   );

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt, input logic inc);
      if (inc && (cnt != CELLS_MAX)) return cnt + CW'(1);
      return cnt;
   endfunction

   always_comb begin
      place_ok = click & cor_valid(player_cor) & ~placed_map_q[player_cor];
      shot_ok  = click & cor_valid(enemy_cor) & ~shot_map_q[enemy_cor];
   end

   always_comb begin
      place_we_d   = 1'b0;
      place_cor_d  = place_cor_q;
      shot_cor_d   = shot_cor_q;
      placed_map_d = placed_map_q;
      shot_map_d   = shot_map_q;
      placed_cnt_d = placed_cnt_q;
      hits_enemy_d = hits_enemy_q;
      hits_mine_d  = hits_mine_q;
      timer_d      = timer_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               placed_map_d = '0;
               shot_map_d   = '0;
               placed_cnt_d = '0;
               hits_enemy_d = '0;
               hits_mine_d  = '0;
               shot_cor_d   = NO_COR;
            end
         end
         PLACE: begin
            if (place_ok) begin
               place_we_d               = 1'b1;
               place_cor_d              = player_cor;
               placed_map_d[player_cor] = 1'b1;
               placed_cnt_d             = placed_cnt_q + CW'(1);
            end
         end
         PLAYER_TURN: begin
            if (shot_ok) begin
               shot_cor_d            = enemy_cor;
               shot_map_d[enemy_cor] = 1'b1;
            end
         end
         SEND: begin
            if (shot_ready) timer_d = '0;
         end
         WAIT_RES: begin
            timer_d = timer_q + TW'(1);
            if (res_valid) hits_enemy_d = sat_inc(hits_enemy_q, res_hit);
         end
         ENEMY_TURN: begin
            if (inc_valid) hits_mine_d = sat_inc(hits_mine_q, inc_hit);
         end
         WIN, LOSE: begin
            if (start) begin
               hits_enemy_d = '0;
               hits_mine_d  = '0;
            end
         end
         default: ;
      endcase
   end

   // next-state logic; a result arriving on the timeout cycle takes priority
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:        if (start) state_d = PLACE;
         PLACE:       if (place_ok && (placed_cnt_d == CELLS_MAX)) state_d = READY;
         READY:       if (start) state_d = (FIRST_PLAYER != 0) ? PLAYER_TURN : ENEMY_TURN;
         PLAYER_TURN: if (shot_ok) state_d = SEND;
         SEND:        if (shot_ready) state_d = WAIT_RES;
         WAIT_RES: begin
            if (res_valid) begin
               if (hits_enemy_d == CELLS_MAX) state_d = WIN;
               else if (res_hit)              state_d = PLAYER_TURN;
               else                           state_d = ENEMY_TURN;
            end else if (timer_q == TMO_LAST) begin
               state_d = SEND;
            end
         end
         ENEMY_TURN: begin
            if (inc_valid) begin
               if (hits_mine_d == CELLS_MAX) state_d = LOSE;
               else if (!inc_hit)            state_d = PLAYER_TURN;
            end
         end
         WIN, LOSE:   if (start) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         place_we_q   <= 1'b0;
         place_cor_q  <= '0;
         shot_cor_q   <= NO_COR;
         placed_map_q <= '0;
         shot_map_q   <= '0;
         placed_cnt_q <= '0;
         hits_enemy_q <= '0;
         hits_mine_q  <= '0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         place_we_q   <= place_we_d;
         place_cor_q  <= place_cor_d;
         shot_cor_q   <= shot_cor_d;
         placed_map_q <= placed_map_d;
         shot_map_q   <= shot_map_d;
         placed_cnt_q <= placed_cnt_d;
         hits_enemy_q <= hits_enemy_d;
         hits_mine_q  <= hits_mine_d;
         timer_q      <= timer_d;
      end
   end

   always_comb begin
      state      = state_q;
      my_turn    = (state_q == PLAYER_TURN);
      win        = (state_q == WIN);
      lose       = (state_q == LOSE);
      shot_valid = (state_q == SEND);
      shot_cor   = shot_cor_q;
      place_we   = place_we_q;
      place_cor  = place_cor_q;
      hits_enemy = hits_enemy_q;
      hits_mine  = hits_mine_q;
   end

endmodule
